// File: rtl/aux_bus_arbiter.sv
// Two-port round-robin arbiter that serialises CPU and host/UART-bridge accesses onto a
// single aux bus. Every access runs IDLE -> ACCESS -> COMPLETE, with all outputs registered.
module aux_bus_arbiter #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  reset_i,

    input  logic                  req0_i,
    input  logic                  we0_i,
    input  logic [ADDR_WIDTH-1:0] adr0_i,
    input  logic [DATA_WIDTH-1:0] dat0_i,
    output logic                  ack0_o,
    output logic [DATA_WIDTH-1:0] rdat0_o,

    input  logic                  req1_i,
    input  logic                  we1_i,
    input  logic [ADDR_WIDTH-1:0] adr1_i,
    input  logic [DATA_WIDTH-1:0] dat1_i,
    output logic                  ack1_o,
    output logic [DATA_WIDTH-1:0] rdat1_o,

    output logic [ADDR_WIDTH-1:0] mem_adr_o,
    output logic [DATA_WIDTH-1:0] mem_dat_o,
    output logic                  mem_we_o,
    output logic                  mem_re_o,
    input  logic [DATA_WIDTH-1:0] mem_dat_i,

    output logic                  busy_o,
    output logic                  gnt_o
);

    typedef enum logic [1:0] {StIdle, StAccess, StComplete} state_e;

    state_e state_q;
    logic   last_gnt_q;
    logic   we_q;
    logic   winner;

    // A lone requester always wins; on a tie the port not served last time goes next.
    always_comb begin
        winner = req1_i;
        if (req0_i && req1_i) begin
            winner = ~last_gnt_q;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= StIdle;
            last_gnt_q <= 1'b1;
            we_q       <= 1'b0;
            gnt_o      <= 1'b0;
            busy_o     <= 1'b0;
            ack0_o     <= 1'b0;
            ack1_o     <= 1'b0;
            mem_we_o   <= 1'b0;
            mem_re_o   <= 1'b0;
            mem_adr_o  <= '0;
            mem_dat_o  <= '0;
            rdat0_o    <= '0;
            rdat1_o    <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (req0_i || req1_i) begin
                        gnt_o      <= winner;
                        last_gnt_q <= winner;
                        busy_o     <= 1'b1;
                        state_q    <= StAccess;
                        // mem_adr_o/mem_dat_o double as the latched request for the access.
                        if (winner) begin
                            we_q      <= we1_i;
                            mem_adr_o <= adr1_i;
                            mem_dat_o <= dat1_i;
                            mem_we_o  <= we1_i;
                            mem_re_o  <= ~we1_i;
                        end else begin
                            we_q      <= we0_i;
                            mem_adr_o <= adr0_i;
                            mem_dat_o <= dat0_i;
                            mem_we_o  <= we0_i;
                            mem_re_o  <= ~we0_i;
                        end
                    end
                end
                StAccess: begin
                    mem_we_o <= 1'b0;
                    mem_re_o <= 1'b0;
                    if (!we_q) begin
                        if (gnt_o) begin
                            rdat1_o <= mem_dat_i;
                        end else begin
                            rdat0_o <= mem_dat_i;
                        end
                    end
                    ack0_o  <= ~gnt_o;
                    ack1_o  <= gnt_o;
                    state_q <= StComplete;
                end
                StComplete: begin
                    ack0_o  <= 1'b0;
                    ack1_o  <= 1'b0;
                    busy_o  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aux_bus_arbiter.sv
// Directed bench for aux_bus_arbiter: single accesses, tie-breaking, contention,
// reset abort and input stability, against hand-computed expectations.
module tb_aux_bus_arbiter;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        req0_i, we0_i, req1_i, we1_i;
    logic [15:0] adr0_i, adr1_i;
    logic [7:0]  dat0_i, dat1_i;
    logic        ack0_o, ack1_o;
    logic [7:0]  rdat0_o, rdat1_o;
    logic [15:0] mem_adr_o;
    logic [7:0]  mem_dat_o;
    logic        mem_we_o, mem_re_o;
    logic [7:0]  mem_dat_i;
    logic        busy_o, gnt_o;

    int passed = 0;
    int total  = 0;

    always #5 clk_i = ~clk_i;

    // Read-only aux memory: 0x00FF holds 0xC3, everything else returns low address byte ^ 0xA5.
    assign mem_dat_i = (mem_adr_o == 16'h00FF) ? 8'hC3 : (mem_adr_o[7:0] ^ 8'hA5);

    aux_bus_arbiter #(
        .ADDR_WIDTH(16),
        .DATA_WIDTH(8)
    ) dut (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .req0_i   (req0_i),
        .we0_i    (we0_i),
        .adr0_i   (adr0_i),
        .dat0_i   (dat0_i),
        .ack0_o   (ack0_o),
        .rdat0_o  (rdat0_o),
        .req1_i   (req1_i),
        .we1_i    (we1_i),
        .adr1_i   (adr1_i),
        .dat1_i   (dat1_i),
        .ack1_o   (ack1_o),
        .rdat1_o  (rdat1_o),
        .mem_adr_o(mem_adr_o),
        .mem_dat_o(mem_dat_o),
        .mem_we_o (mem_we_o),
        .mem_re_o (mem_re_o),
        .mem_dat_i(mem_dat_i),
        .busy_o   (busy_o),
        .gnt_o    (gnt_o)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " gnt"}, 32'(gnt_o), 32'h0);
        check({tag, " busy"}, 32'(busy_o), 32'h0);
        check({tag, " acks"}, 32'({ack1_o, ack0_o}), 32'h0);
        check({tag, " strobes"}, 32'({mem_we_o, mem_re_o}), 32'h0);
        check({tag, " mem_adr"}, 32'(mem_adr_o), 32'h0);
        check({tag, " mem_dat"}, 32'(mem_dat_o), 32'h0);
        check({tag, " rdat0"}, 32'(rdat0_o), 32'h0);
        check({tag, " rdat1"}, 32'(rdat1_o), 32'h0);
    endtask

    initial begin
        logic exp_g;
        reset_i = 1'b1;
        req0_i = 1'b0; we0_i = 1'b0; adr0_i = '0; dat0_i = '0;
        req1_i = 1'b0; we1_i = 1'b0; adr1_i = '0; dat1_i = '0;
        tick();
        tick();
        check_reset_outputs("por");
        reset_i = 1'b0;
        tick();

        // Single write on port 0
        req0_i = 1'b1; we0_i = 1'b1; adr0_i = 16'h1234; dat0_i = 8'h5A;
        tick();
        check("wr access we", 32'({mem_we_o, mem_re_o}), 32'b10);
        check("wr access adr", 32'(mem_adr_o), 32'h1234);
        check("wr access dat", 32'(mem_dat_o), 32'h5A);
        check("wr access busy/gnt", 32'({busy_o, gnt_o}), 32'b10);
        check("wr access no ack", 32'({ack1_o, ack0_o}), 32'b00);
        tick();
        check("wr complete ack", 32'({ack1_o, ack0_o}), 32'b01);
        check("wr complete strobes", 32'({mem_we_o, mem_re_o}), 32'b00);
        req0_i = 1'b0;
        tick();
        check("wr idle", 32'({busy_o, ack1_o, ack0_o}), 32'b000);

        // Single read on port 1, then a port 1 write must leave rdat1 alone
        req1_i = 1'b1; we1_i = 1'b0; adr1_i = 16'h00FF; dat1_i = 8'h00;
        tick();
        check("rd access strobes", 32'({mem_we_o, mem_re_o}), 32'b01);
        check("rd access adr/gnt", 32'({mem_adr_o, 7'b0, gnt_o}), {16'h00FF, 8'h01});
        tick();
        check("rd complete ack", 32'({ack1_o, ack0_o}), 32'b10);
        check("rd complete rdat1", 32'(rdat1_o), 32'hC3);
        check("rd complete strobes", 32'({mem_we_o, mem_re_o}), 32'b00);
        we1_i = 1'b1; dat1_i = 8'h99;
        tick();
        check("rd idle ack", 32'({ack1_o, ack0_o}), 32'b00);
        tick();
        check("wr1 access we", 32'({mem_we_o, mem_re_o}), 32'b10);
        tick();
        req1_i = 1'b0;
        tick();
        check("rdat1 holds over write", 32'(rdat1_o), 32'hC3);
        check("rdat0 untouched", 32'(rdat0_o), 32'h00);

        // Reset, then a tie must go to port 0 first
        reset_i = 1'b1;
        tick();
        check_reset_outputs("reset2");
        reset_i = 1'b0;
        req0_i = 1'b1; we0_i = 1'b1; adr0_i = 16'h0010; dat0_i = 8'h11;
        req1_i = 1'b1; we1_i = 1'b1; adr1_i = 16'h0020; dat1_i = 8'h22;
        tick();
        check("tie first gnt", 32'(gnt_o), 32'h0);
        check("tie first adr", 32'(mem_adr_o), 32'h0010);
        tick();
        check("tie first ack", 32'({ack1_o, ack0_o}), 32'b01);
        req0_i = 1'b0;
        tick();
        tick();
        check("tie second gnt", 32'(gnt_o), 32'h1);
        check("tie second adr/dat", 32'({mem_adr_o, mem_dat_o}), {8'h0, 16'h0020, 8'h22});
        tick();
        check("tie second ack", 32'({ack1_o, ack0_o}), 32'b10);
        req1_i = 1'b0;
        tick();

        // Continuous contention: 8 reads, grants alternate starting with port 0
        req0_i = 1'b1; we0_i = 1'b0; adr0_i = 16'h0040;
        req1_i = 1'b1; we1_i = 1'b0; adr1_i = 16'h0050;
        for (int i = 0; i < 8; i++) begin
            exp_g = (i % 2) == 1;
            tick();
            check("contend gnt", 32'(gnt_o), 32'(exp_g));
            check("contend no early ack", 32'({ack1_o, ack0_o}), 32'b00);
            tick();
            check("contend ack", 32'({ack1_o, ack0_o}), exp_g ? 32'b10 : 32'b01);
            if (i == 7) begin
                req0_i = 1'b0;
                req1_i = 1'b0;
            end
            tick();
            check("contend idle", 32'(busy_o), 32'h0);
        end
        check("contend rdat0", 32'(rdat0_o), 32'hE5);
        check("contend rdat1", 32'(rdat1_o), 32'hF5);

        // Reset during ACCESS of a port 1 write aborts it
        req1_i = 1'b1; we1_i = 1'b1; adr1_i = 16'h0077; dat1_i = 8'h33;
        tick();
        check("abort access we", 32'(mem_we_o), 32'h1);
        reset_i = 1'b1;
        req1_i = 1'b0;
        #1;
        check_reset_outputs("abort async");
        tick();
        check("abort no ack in reset", 32'({ack1_o, ack0_o}), 32'b00);
        reset_i = 1'b0;
        tick();
        check("abort no ack after", 32'({ack1_o, ack0_o, busy_o}), 32'b000);
        tick();
        check("abort still idle", 32'({ack1_o, ack0_o, busy_o}), 32'b000);

        // Address changes during ACCESS/COMPLETE do not affect the access in progress
        req0_i = 1'b1; we0_i = 1'b0; adr0_i = 16'h0040;
        tick();
        check("stab access adr", 32'(mem_adr_o), 32'h0040);
        adr0_i = 16'h0099;
        tick();
        check("stab complete ack", 32'({ack1_o, ack0_o}), 32'b01);
        check("stab complete rdat0", 32'(rdat0_o), 32'hE5);
        check("stab complete adr", 32'(mem_adr_o), 32'h0040);
        adr0_i = 16'h0050;
        tick();
        check("stab idle adr", 32'(mem_adr_o), 32'h0040);
        tick();
        check("stab next adr", 32'(mem_adr_o), 32'h0050);
        tick();
        check("stab next rdat0", 32'(rdat0_o), 32'hF5);
        req0_i = 1'b0;
        tick();
        check("final idle", 32'({busy_o, ack1_o, ack0_o}), 32'b000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
